// File: rtl/hs32_regfile.sv
// Two-bank register file (user + shadow) with a post-reset clear sweep and
// same-cycle write-through bypass on both read ports.
module hs32_regfile #(
  parameter int NREGS        = 16,
  parameter int WIDTH        = 32,
  parameter int CLR_ON_RESET = 1,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bank_i,
  input  logic [AW-1:0]    wp_addr_i,
  input  logic [WIDTH-1:0] wp_data_i,
  input  logic             wp_we1_i,
  input  logic             wp_we2_i,
  input  logic [AW-1:0]    rp1_addr_i,
  output logic [WIDTH-1:0] rp1_data_o,
  input  logic [AW-1:0]    rp2_addr_i,
  output logic [WIDTH-1:0] rp2_data_o,
  output logic             ready_o
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic [WIDTH-1:0] bank0 [NREGS];
  logic [WIDTH-1:0] bank1 [NREGS];
  logic             sel_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= (CLR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        READY: ready_o <= 1'b1;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage carries no reset; the sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      bank0[clr_cnt] <= '0;
      bank1[clr_cnt] <= '0;
    end else begin
      if (wp_we1_i) bank0[wp_addr_i] <= wp_data_i;
      if (wp_we2_i) bank1[wp_addr_i] <= wp_data_i;
    end
  end

  // Only a write into the bank being read may bypass.
  assign sel_we = bank_i ? wp_we2_i : wp_we1_i;

  always_comb begin
    rp1_data_o = '0;
    rp2_data_o = '0;
    if (state == READY) begin
      if (sel_we && (rp1_addr_i == wp_addr_i))
        rp1_data_o = wp_data_i;
      else
        rp1_data_o = bank_i ? bank1[rp1_addr_i] : bank0[rp1_addr_i];
      if (sel_we && (rp2_addr_i == wp_addr_i))
        rp2_data_o = wp_data_i;
      else
        rp2_data_o = bank_i ? bank1[rp2_addr_i] : bank0[rp2_addr_i];
    end
  end

endmodule
